// File: rtl/morphle_ycell.sv
// Morphle Logic "yellow cell": serially configured tile moving dual-rail data down/right and acks up/left.
// Optional define YCELL_NCELL_EN turns code 101 into the inverted 'N' match cell (otherwise it is a space).
module morphle_ycell (
    input  logic       clk,
    input  logic       reset,
    input  logic       confclk,
    input  logic       cbitin,
    output logic       cbitout,
    output logic       hempty,
    output logic       vempty,
    input  logic       uempty,
    input  logic       dempty,
    input  logic       lempty,
    input  logic       rempty,
    input  logic [1:0] uin,
    input  logic [1:0] din,
    input  logic [1:0] lin,
    input  logic [1:0] rin,
    output logic [1:0] uout,
    output logic [1:0] dout,
    output logic [1:0] lout,
    output logic [1:0] rout
);
    localparam logic [2:0] CODE_CROSS  = 3'b100;
    localparam logic [2:0] CODE_HWIRE  = 3'b010;
    localparam logic [2:0] CODE_VWIRE  = 3'b110;
    localparam logic [2:0] CODE_YMATCH = 3'b001;
`ifdef YCELL_NCELL_EN
    localparam logic [2:0] CODE_NMATCH = 3'b101;
`endif
    localparam logic [1:0] DR_NULL = 2'b00;
    localparam logic [1:0] DR_ZERO = 2'b01;
    localparam logic [1:0] DR_ONE  = 2'b10;

    logic [2:0] cfg_reg;
    logic       confclk_prev_reg;
    logic       is_match;
    logic       is_inv;
    logic [1:0] u_val, d_val, l_val, r_val, v_val, match_val;
    logic [1:0] uout_next, dout_next, lout_next, rout_next;

    // Top/left boundary flags are never consulted: those edges are fed by array I/O.
    logic unused_edge;
    assign unused_edge = uempty ^ lempty;

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_reg          <= 3'b000;
            confclk_prev_reg <= 1'b0;
        end else begin
            confclk_prev_reg <= confclk;
            if (confclk && !confclk_prev_reg)
                cfg_reg <= {cbitin, cfg_reg[2:1]};
        end
    end

    assign cbitout = cfg_reg[0];

    always_comb begin
        hempty   = 1'b1;
        vempty   = 1'b1;
        is_match = 1'b0;
        is_inv   = 1'b0;
        case (cfg_reg)
            CODE_CROSS:  begin hempty = 1'b0; vempty = 1'b0; end
            CODE_HWIRE:  hempty = 1'b0;
            CODE_VWIRE:  vempty = 1'b0;
            CODE_YMATCH: begin hempty = 1'b0; vempty = 1'b0; is_match = 1'b1; end
`ifdef YCELL_NCELL_EN
            CODE_NMATCH: begin hempty = 1'b0; vempty = 1'b0; is_match = 1'b1; is_inv = 1'b1; end
`endif
            default: ;
        endcase
    end

    function automatic logic [1:0] clean(input logic [1:0] x);
        return (x == 2'b11) ? DR_NULL : x;
    endfunction

    always_comb begin
        u_val = clean(uin);
        d_val = clean(din);
        l_val = clean(lin);
        r_val = clean(rin);
        // Swapping the rails complements a valid value and leaves null untouched.
        v_val = is_inv ? {u_val[0], u_val[1]} : u_val;
        if (l_val == DR_NULL || v_val == DR_NULL)
            match_val = DR_NULL;
        else if (l_val == DR_ONE && v_val == DR_ONE)
            match_val = DR_ONE;
        else
            match_val = DR_ZERO;

        dout_next = vempty ? DR_NULL : u_val;
        uout_next = vempty ? DR_NULL : (dempty ? dout_next : d_val);
        rout_next = hempty ? DR_NULL : (is_match ? match_val : l_val);
        lout_next = hempty ? DR_NULL : (rempty ? rout_next : r_val);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            uout <= DR_NULL;
            dout <= DR_NULL;
            lout <= DR_NULL;
            rout <= DR_NULL;
        end else begin
            uout <= uout_next;
            dout <= dout_next;
            lout <= lout_next;
            rout <= rout_next;
        end
    end
endmodule

// File: tb/tb_morphle_ycell.sv
// Randomized + directed bench for morphle_ycell against a value-level model of the cell rules.
module tb_morphle_ycell;
    logic       clk = 1'b0;
    logic       reset, confclk, cbitin;
    logic       cbitout, hempty, vempty;
    logic       uempty, dempty, lempty, rempty;
    logic [1:0] uin, din, lin, rin;
    logic [1:0] uout, dout, lout, rout;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    morphle_ycell dut (
        .clk(clk), .reset(reset), .confclk(confclk), .cbitin(cbitin),
        .cbitout(cbitout), .hempty(hempty), .vempty(vempty),
        .uempty(uempty), .dempty(dempty), .lempty(lempty), .rempty(rempty),
        .uin(uin), .din(din), .lin(lin), .rin(rin),
        .uout(uout), .dout(dout), .lout(lout), .rout(rout)
    );

    always #5 clk = ~clk;

    localparam int K_SPACE = 0, K_PLUS = 1, K_HWIRE = 2, K_VWIRE = 3, K_Y = 4, K_N = 5;
    localparam int NUL = -1;

    // Model state: configuration as an integer code and logical values of outputs.
    int m_cfg = 0;
    bit m_prev = 0;
    int e_u = NUL, e_d = NUL, e_l = NUL, e_r = NUL;

    function automatic int kind(input int code);
        case (code)
            4: return K_PLUS;
            2: return K_HWIRE;
            6: return K_VWIRE;
            1: return K_Y;
`ifdef YCELL_NCELL_EN
            5: return K_N;
`endif
            default: return K_SPACE;
        endcase
    endfunction

    function automatic int val(input logic [1:0] x);
        if (x === 2'b01) return 0;
        if (x === 2'b10) return 1;
        return NUL;
    endfunction

    function automatic logic [1:0] enc(input int v);
        if (v == 0) return 2'b01;
        if (v == 1) return 2'b10;
        return 2'b00;
    endfunction

    task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        int k, u, l, v;
        bit hblk, vblk;
        @(posedge clk);
        cyc++;
        if (reset) begin
            m_cfg = 0; m_prev = 0;
            e_u = NUL; e_d = NUL; e_l = NUL; e_r = NUL;
        end else begin
            k = kind(m_cfg);
            hblk = (k == K_SPACE || k == K_VWIRE);
            vblk = (k == K_SPACE || k == K_HWIRE);
            u = val(uin);
            l = val(lin);
            e_d = vblk ? NUL : u;
            e_u = vblk ? NUL : (dempty ? e_d : val(din));
            if (hblk) e_r = NUL;
            else if (k == K_Y || k == K_N) begin
                v = (k == K_N && u != NUL) ? 1 - u : u;
                e_r = (l == NUL || v == NUL) ? NUL : (l & v);
            end else e_r = l;
            e_l = hblk ? NUL : (rempty ? e_r : val(rin));
            if (confclk && !m_prev) m_cfg = (int'(cbitin) << 2) | (m_cfg >> 1);
            m_prev = confclk;
        end
        #1;
        k = kind(m_cfg);
        check("flags", {cbitout, hempty, vempty},
              {m_cfg[0], k == K_SPACE || k == K_VWIRE, k == K_SPACE || k == K_HWIRE});
        check("dout", {1'b0, dout}, {1'b0, enc(e_d)});
        check("uout", {1'b0, uout}, {1'b0, enc(e_u)});
        check("rout", {1'b0, rout}, {1'b0, enc(e_r)});
        check("lout", {1'b0, lout}, {1'b0, enc(e_l)});
        $display("cyc=%0d rst=%b cfg=%03b u=%b d=%b l=%b r=%b de=%b re=%b -> dout=%b uout=%b rout=%b lout=%b",
                 cyc, reset, m_cfg[2:0], uin, din, lin, rin, dempty, rempty, dout, uout, rout, lout);
    endtask

    task automatic strobe(input logic b);
        cbitin = b; confclk = 1'b1; step();
        confclk = 1'b0; step();
    endtask

    task automatic load3(input logic b0, input logic b1, input logic b2);
        strobe(b0); strobe(b1); strobe(b2);
    endtask

    task automatic do_reset();
        reset = 1'b1; step(); step();
        reset = 1'b0;
    endtask

    task automatic set_data(input logic [1:0] u, input logic [1:0] d, input logic [1:0] l,
                            input logic [1:0] r, input logic de, input logic re);
        uin = u; din = d; lin = l; rin = r; dempty = de; rempty = re;
    endtask

    initial begin
        reset = 1'b1; confclk = 1'b0; cbitin = 1'b0;
        uempty = 1'b0; lempty = 1'b0;
        set_data(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);

        // Reset state, then confclk pulses under reset must be ignored.
        step(); step();
        check("rst_flags", {cbitout, hempty, vempty}, 3'b011);
        check("rst_dout", {1'b0, dout}, 3'b000);
        cbitin = 1'b1;
        for (int i = 0; i < 4; i++) begin
            confclk = ~confclk; step();
        end
        confclk = 1'b0; step();
        reset = 1'b0; step();
        check("rst_conf_ignored", {cbitout, hempty, vempty}, 3'b011);

        // '+' crossing.
        load3(1'b0, 1'b0, 1'b1);
        check("plus_flags", {1'b0, hempty, vempty}, 3'b000);
        set_data(2'b10, 2'b01, 2'b01, 2'b10, 1'b0, 1'b0); step();
        check("plus_dout", {1'b0, dout}, 3'b010);
        check("plus_rout", {1'b0, rout}, 3'b001);
        check("plus_uout", {1'b0, uout}, 3'b001);
        check("plus_lout", {1'b0, lout}, 3'b010);

        // '|' vertical wire with bottom echo.
        load3(1'b0, 1'b1, 1'b1);
        set_data(2'b10, 2'b01, 2'b10, 2'b01, 1'b1, 1'b0); step();
        check("vbar_dout_uout", {dout[1], uout}, 3'b110);
        check("vbar_h_routlout", {hempty, rout | lout}, 3'b100);

        // '-' horizontal wire.
        load3(1'b0, 1'b1, 1'b0);
        set_data(2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0); step();
        check("hbar_rout", {1'b0, rout}, 3'b010);
        check("hbar_v_dout", {vempty, dout}, 3'b100);

        // 'Y' match cell.
        load3(1'b1, 1'b0, 1'b0);
        set_data(2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0); step();
        check("y_11", {1'b0, rout}, 3'b010);
        uin = 2'b01; step();
        check("y_01", {1'b0, rout}, 3'b001);
        uin = 2'b00; step();
        check("y_null", {1'b0, rout}, 3'b000);
        uin = 2'b10; rempty = 1'b1; step();
        check("y_echo", {1'b0, lout}, {1'b0, rout});
        check("y_echo_val", {1'b0, lout}, 3'b010);

        // Code 101.
        load3(1'b1, 1'b0, 1'b1);
        set_data(2'b01, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0); step();
`ifdef YCELL_NCELL_EN
        check("n_rout_h", {hempty, rout}, 3'b010);
`else
        check("n_off", {rout, hempty, vempty}, 4'b0011 & 3'b111 | 3'b000);
        check("n_off_rout", {1'b0, rout}, 3'b000);
`endif

        // Chain: cbitout sequence 0,0,1,0, then a held confclk shifts only once.
        do_reset();
        strobe(1'b1); check("chain1", {2'b00, cbitout}, 3'b000);
        strobe(1'b0); check("chain2", {2'b00, cbitout}, 3'b000);
        strobe(1'b0); check("chain3", {2'b00, cbitout}, 3'b001);
        strobe(1'b1); check("chain4", {2'b00, cbitout}, 3'b000);
        do_reset();
        cbitin = 1'b1; confclk = 1'b1;
        for (int i = 0; i < 5; i++) step();
        confclk = 1'b0; step();
        check("hold_once", {1'b0, cbitout, hempty}, 3'b000);

        // Randomized traffic with live reconfiguration and occasional resets.
        for (int i = 0; i < 400; i++) begin
            uin = 2'($urandom); din = 2'($urandom); lin = 2'($urandom); rin = 2'($urandom);
            dempty = 1'($urandom); rempty = 1'($urandom);
            uempty = 1'($urandom); lempty = 1'($urandom);
            cbitin = 1'($urandom);
            confclk = ($urandom_range(0, 2) == 0) ? ~confclk : confclk;
            reset = ($urandom_range(0, 60) == 0);
            step();
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
